// File: rtl/mem_responder_if.sv
// mem_responder_if: CPU memory bus between the cpu (master) and mem_responder (slave).
//   mem_cmd    master->slave  00=NONE, 01=READ, 10=WRITE, 11=illegal
//   mem_addr   master->slave  request address
//   write_data master->slave  store data, sampled with WRITE
//   read_data  slave->master  registered read response
//   rd_valid   slave->master  one-cycle pulse per accepted READ
// Handshake: every rising edge carries one request. The slave has no
// back-pressure. rd_valid is high in the cycle after each READ edge, and
// read_data is valid while rd_valid is high.
interface mem_responder_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 9
) ();
  logic [1:0]        mem_cmd;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] write_data;
  logic [DATA_W-1:0] read_data;
  logic              rd_valid;

  modport master (
    output mem_cmd, mem_addr, write_data,
    input  read_data, rd_valid
  );

  modport slave (
    input  mem_cmd, mem_addr, write_data,
    output read_data, rd_valid
  );
endinterface

// File: rtl/mem_responder.sv
// mem_responder: memory-side responder for the CPU bus. Decodes three regions:
// on-chip RAM (0..RAM_DEPTH-1), a read-only switch port (SW_ADDR) and a
// write-only LED register (LED_ADDR). Everything else is unmapped.
// Ports:
//   clk         system clock, rising edge
//   reset       asynchronous active-low reset
//   bus         mem_responder_if slave (cmd/addr/wdata in, rdata/rd_valid out)
//   SW          raw board switches, asynchronous to clk
//   LEDR        LED register contents
//   bus_err     sticky error flag, cleared only by reset
//   state_dbg_o current FSM state (0=IDLE, 1=RESP)
module mem_responder #(
  parameter int              DATA_W    = 16,
  parameter int              ADDR_W    = 9,
  parameter int              RAM_DEPTH = 256,
  parameter logic [ADDR_W-1:0] LED_ADDR = 9'h100,
  parameter logic [ADDR_W-1:0] SW_ADDR  = 9'h140
) (
  input  logic                clk,
  input  logic                reset,
  mem_responder_if.slave      bus,
  input  logic [7:0]          SW,
  output logic [7:0]          LEDR,
  output logic                bus_err,
  output logic                state_dbg_o
);

  localparam int RAM_AW = $clog2(RAM_DEPTH);
  // One extra bit so RAM_DEPTH itself is representable in the compare.
  localparam logic [ADDR_W:0] RAM_LIMIT = (ADDR_W+1)'(RAM_DEPTH);

  typedef enum logic {IDLE = 1'b0, RESP = 1'b1} state_t;

  logic [DATA_W-1:0] ram [RAM_DEPTH];

  state_t            state_q, state_d;
  logic [DATA_W-1:0] read_data_q, read_data_d;
  logic [7:0]        leds_q, leds_d;
  logic              bus_err_q, bus_err_d;
  logic [7:0]        sw_s1_q, sw_s2_q;

  logic              is_read, is_write, is_ill;
  logic              hit_ram, hit_led, hit_sw;
  logic [RAM_AW-1:0] ram_idx;

  always_comb begin
    is_read  = (bus.mem_cmd == 2'b01);
    is_write = (bus.mem_cmd == 2'b10);
    is_ill   = (bus.mem_cmd == 2'b11);
    hit_ram  = ({1'b0, bus.mem_addr} < RAM_LIMIT);
    hit_led  = (bus.mem_addr == LED_ADDR);
    hit_sw   = (bus.mem_addr == SW_ADDR);
    ram_idx  = bus.mem_addr[RAM_AW-1:0];
  end

  always_comb begin
    state_d     = is_read ? RESP : IDLE;
    read_data_d = read_data_q;
    leds_d      = leds_q;
    bus_err_d   = bus_err_q;
    if (is_read) begin
      if (hit_ram) begin
        read_data_d = ram[ram_idx];
      end else if (hit_sw) begin
        read_data_d = {{(DATA_W-8){1'b0}}, sw_s2_q};
      end else begin
        read_data_d = '0;
        bus_err_d   = 1'b1;
      end
    end
    if (is_write) begin
      if (hit_led) begin
        leds_d = bus.write_data[7:0];
      end else if (!hit_ram) begin
        // Writes to the read-only switch port land here as well.
        bus_err_d = 1'b1;
      end
    end
    if (is_ill) begin
      bus_err_d = 1'b1;
    end
  end

  // FSM plus all registered outputs; rd_valid is the RESP state itself.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      read_data_q <= '0;
      leds_q      <= '0;
      bus_err_q   <= 1'b0;
      sw_s1_q     <= '0;
      sw_s2_q     <= '0;
    end else begin
      state_q     <= state_d;
      read_data_q <= read_data_d;
      leds_q      <= leds_d;
      bus_err_q   <= bus_err_d;
      sw_s1_q     <= SW;
      sw_s2_q     <= sw_s1_q;
    end
  end

  // RAM contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (is_write && hit_ram) begin
      ram[ram_idx] <= bus.write_data;
    end
  end

  assign bus.read_data = read_data_q;
  assign bus.rd_valid  = (state_q == RESP);
  assign LEDR          = leds_q;
  assign bus_err       = bus_err_q;
  assign state_dbg_o   = state_q;

endmodule
